// File: rtl/ram_copy_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_engine_if
//  Purpose  : RAM port bundle between the copy engine (master) and ram16k (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface ram_copy_engine_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_add;
    logic [DATA_W-1:0] mem_d_in;
    logic              mem_w;
    logic              mem_r;
    logic              mem_en;
    logic [DATA_W-1:0] mem_d_out;

    modport master (
        output mem_add, mem_d_in, mem_w, mem_r, mem_en,
        input  mem_d_out
    );

    modport slave (
        input  mem_add, mem_d_in, mem_w, mem_r, mem_en,
        output mem_d_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ram_copy_engine
//  Purpose  : Forward block copy of len words from src_add to dst_add, one read
//             and one write cycle per word. Optional RAM_COPY_CHECKSUM_EN adds a
//             running 16-bit sum of copied words on the checksum port.
//  Revision : 1.0  initial release
// ============================================================================
module ram_copy_engine #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 15
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] src_add,
    input  wire logic [ADDR_W-1:0] dst_add,
    input  wire logic [LEN_W-1:0]  len,
    output logic                   busy,
    output logic                   done,
`ifdef RAM_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0]      checksum,
`endif
    ram_copy_engine_if.master      mem
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  c_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  c_LEN_ZERO = '0;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;

    logic [LEN_W-1:0]  w_count_next;
    logic              w_last;

    assign w_count_next = r_count + c_LEN_ONE;
    assign w_last       = (w_count_next == r_len);

    // Strobes are registered from the state transition so they line up with
    // the state they belong to; mem_d_in doubles as the read-data hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_src_ptr    <= '0;
            r_dst_ptr    <= '0;
            r_len        <= '0;
            r_count      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem.mem_add  <= '0;
            mem.mem_d_in <= '0;
            mem.mem_w    <= 1'b0;
            mem.mem_r    <= 1'b0;
            mem.mem_en   <= 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_src_ptr <= src_add;
                        r_dst_ptr <= dst_add;
                        r_len     <= len;
                        r_count   <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
                        checksum  <= '0;
`endif
                        if (len == c_LEN_ZERO) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= c_READ;
                            busy        <= 1'b1;
                            mem.mem_en  <= 1'b1;
                            mem.mem_r   <= 1'b1;
                            mem.mem_w   <= 1'b0;
                            mem.mem_add <= src_add;
                        end
                    end
                end
                c_READ: begin
                    r_state      <= c_WRITE;
                    r_src_ptr    <= r_src_ptr + c_ADDR_ONE;
                    mem.mem_d_in <= mem.mem_d_out;
                    mem.mem_r    <= 1'b0;
                    mem.mem_w    <= 1'b1;
                    mem.mem_add  <= r_dst_ptr;
                end
                c_WRITE: begin
                    r_dst_ptr <= r_dst_ptr + c_ADDR_ONE;
                    r_count   <= w_count_next;
`ifdef RAM_COPY_CHECKSUM_EN
                    checksum  <= checksum + mem.mem_d_in;
`endif
                    if (w_last) begin
                        r_state    <= c_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        mem.mem_en <= 1'b0;
                        mem.mem_w  <= 1'b0;
                    end else begin
                        r_state     <= c_READ;
                        mem.mem_w   <= 1'b0;
                        mem.mem_r   <= 1'b1;
                        mem.mem_add <= r_src_ptr;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// Bench for ram_copy_engine: behavioural RAM, forward-copy reference model and
// a write scoreboard fed when each copy is launched.
module tb_ram_copy_engine;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int LW = 15;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_add = '0;
    logic [AW-1:0] dst_add = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;

    logic [DW-1:0] ram   [0:(1<<AW)-1];
    logic [DW-1:0] model [0:(1<<AW)-1];
    wr_t           exp_q [$];

    int n_pass  = 0;
    int n_total = 0;

    ram_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    ram_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_add  (src_add),
        .dst_add  (dst_add),
        .len      (len),
        .busy     (busy),
        .done     (done),
`ifdef RAM_COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem      (mem)
    );

    always #5 clk = ~clk;

    assign mem.mem_d_out = (mem.mem_r && mem.mem_en) ? ram[mem.mem_add] : '0;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_a] <= pre_d;
        else if (mem.mem_en && mem.mem_w)
            ram[mem.mem_add] <= mem.mem_d_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Every DUT write must match the next entry queued by the stimulus.
    always @(negedge clk) begin
        wr_t e;
        if (mem.mem_en) check("rw_exclusive", 32'(mem.mem_r & mem.mem_w), 32'd0);
        if (mem.mem_en && mem.mem_w) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem.mem_add), 32'(e.a));
                check("write_data", 32'(mem.mem_d_in), 32'(e.d));
            end
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        model[a] = d;
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input bit poke_mid,
                            input bit poke_done, input string tag);
        int            busy_cnt = 0;
        int            done_at  = 0;
        bit            en_seen  = 1'b0;
        logic [DW-1:0] sum      = '0;
        logic [AW-1:0] sa, da;
        wr_t           w;
        for (int k = 0; k < int'(n); k++) begin
            sa = s + AW'(k);
            da = d + AW'(k);
            model[da] = model[sa];
            w.a = da; w.d = model[da];
            exp_q.push_back(w);
            sum = sum + model[da];
        end
        @(negedge clk);
        src_add = s; dst_add = d; len = n; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2*int'(n) + 4 && done_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (mem.mem_en) en_seen = 1'b1;
            if (done) done_at = c;
            if (poke_mid && c == 3) begin
                start = 1'b1; src_add = s + AW'(100); dst_add = d + AW'(200); len = 2;
            end
            if (poke_mid && c == 4) start = 1'b0;
        end
        check({tag, ".done_cycle"}, 32'(done_at), 32'(2*int'(n) + 1));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(2*int'(n)));
        check({tag, ".mem_en_seen"}, 32'(en_seen), 32'(n != '0));
`ifdef RAM_COPY_CHECKSUM_EN
        check({tag, ".checksum"}, 32'(checksum), 32'(sum));
`endif
        if (poke_done) begin
            start = 1'b1; src_add = s; dst_add = d + AW'(50); len = 2;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".idle_after_done"}, 32'(busy), 32'd0);
        check({tag, ".queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".mem_en"}, 32'(mem.mem_en), 32'd0);
        check({tag, ".mem_r"}, 32'(mem.mem_r), 32'd0);
        check({tag, ".mem_w"}, 32'(mem.mem_w), 32'd0);
        check({tag, ".mem_add"}, 32'(mem.mem_add), 32'd0);
        check({tag, ".mem_d_in"}, 32'(mem.mem_d_in), 32'd0);
`ifdef RAM_COPY_CHECKSUM_EN
        check({tag, ".checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    initial begin
        logic [DW-1:0] pat [4];
        wr_t w;
        bit  done_seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic copy, plus a start pulse in the DONE cycle that must be ignored
        pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
        for (int k = 0; k < 4; k++) poke(AW'(16'h0010 + k), pat[k]);
        run_copy(14'h0010, 14'h0100, 15'd4, 1'b0, 1'b1, "basic");
        for (int k = 0; k < 4; k++) check("basic.ram", 32'(ram[14'h0100 + AW'(k)]), 32'(pat[k]));
`ifdef RAM_COPY_CHECKSUM_EN
        check("basic.checksum_const", 32'(checksum), 32'h0000AAAA);
`endif

        run_copy(14'h0055, 14'h0066, 15'd0, 1'b0, 1'b1, "len0");

        // Source wraps past the top of memory
        pat[0] = 16'h000A; pat[1] = 16'h000B; pat[2] = 16'h000C; pat[3] = 16'h000D;
        poke(14'h3FFE, pat[0]); poke(14'h3FFF, pat[1]);
        poke(14'h0000, pat[2]); poke(14'h0001, pat[3]);
        run_copy(14'h3FFE, 14'h2000, 15'd4, 1'b0, 1'b0, "wrap");
        for (int k = 0; k < 4; k++) check("wrap.ram", 32'(ram[14'h2000 + AW'(k)]), 32'(pat[k]));

        // Second start mid-copy must not disturb the transfer in flight
        run_copy(14'h0010, 14'h0180, 15'd4, 1'b1, 1'b0, "midstart");
        check("midstart.ram0", 32'(ram[14'h0180]), 32'h1111);
        check("midstart.ram3", 32'(ram[14'h0183]), 32'h4444);

        // Reset seen at the edge that opens cycle N+4: only word 0 lands
        poke(14'h0201, 16'hDEAD);
        w.a = 14'h0200; w.d = 16'h1111;
        exp_q.push_back(w);
        model[14'h0200] = 16'h1111;
        @(negedge clk);
        src_add = 14'h0010; dst_add = 14'h0200; len = 15'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("midreset.no_done", 32'(done_seen), 32'd0);
        check("midreset.word0", 32'(ram[14'h0200]), 32'h1111);
        check("midreset.word1_untouched", 32'(ram[14'h0201]), 32'hDEAD);
        check("midreset.queue_drained", 32'(exp_q.size()), 32'd0);

        // Overlapping forward copy replicates the first source word
        poke(14'h0020, 16'h5A5A);
        poke(14'h0021, 16'h0001); poke(14'h0022, 16'h0002); poke(14'h0023, 16'h0003);
        run_copy(14'h0020, 14'h0021, 15'd3, 1'b0, 1'b0, "overlap");
        for (int k = 1; k < 4; k++) check("overlap.ram", 32'(ram[14'h0020 + AW'(k)]), 32'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
